// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one memory read at a time and buffers the
// returned words with their PCs in a small first-word-fall-through queue for decode.
module fetch_queue #(
   parameter int unsigned    DW       = 16,
   parameter int unsigned    AW       = 16,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [AW-1:0]  RESET_PC = 16'h0000,
   parameter logic [AW-1:0]  PC_STEP  = 1,
   parameter logic [3:0]     HALT_OP  = 4'b1111
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic [AW-1:0]            RADDR_CPU,
   output logic                     RREQ,
   input  logic [DW-1:0]            DATA_IN,
   input  logic                     RVALID,
   input  logic                     REDIRECT,
   input  logic [AW-1:0]            REDIRECT_PC,
   input  logic                     STALL,
   output logic [DW-1:0]            IROUT,
   output logic [AW-1:0]            PCOUT,
   output logic                     IRVALID,
   output logic                     HALTED,
   output logic [1:0]               DBG_STATE,
   output logic [$clog2(DEPTH):0]   DBG_COUNT
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] reqpc;
   logic          drop;

   logic [DW-1:0] q_instr [DEPTH];
   logic [AW-1:0] q_pc    [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;

   logic enq;
   logic deq;

   // REDIRECT wins over everything: a response or a dequeue in that cycle is void.
   always_comb begin
      enq = 1'b0;
      deq = 1'b0;
      enq = (state == S_WAIT) && RVALID && !drop && !REDIRECT;
      deq = (count != '0) && !STALL && !REDIRECT;
   end

   always_ff @(posedge CLK) begin
      if (enq && !RST) begin
         q_instr[wr_ptr] <= DATA_IN;
         q_pc[wr_ptr]    <= reqpc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_RUN;
         pc        <= RESET_PC;
         reqpc     <= RESET_PC;
         drop      <= 1'b0;
         RADDR_CPU <= RESET_PC;
         RREQ      <= 1'b0;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         RREQ <= 1'b0;
         if (REDIRECT) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= REDIRECT_PC;
            // An outstanding read whose data has not arrived must be swallowed later.
            if (state == S_WAIT && !RVALID) begin
               drop <= 1'b1;
            end else begin
               drop  <= 1'b0;
               state <= S_RUN;
            end
         end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
            case (state)
               S_RUN: begin
                  if (count < FULL) begin
                     RREQ      <= 1'b1;
                     RADDR_CPU <= pc;
                     reqpc     <= pc;
                     state     <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (RVALID) begin
                     if (drop) begin
                        drop  <= 1'b0;
                        state <= S_RUN;
                     end else begin
                        pc    <= reqpc + PC_STEP;
                        state <= (DATA_IN[DW-1:DW-4] == HALT_OP) ? S_HALT : S_RUN;
                     end
                  end
               end
               S_HALT:  state <= S_HALT;
               default: state <= S_RUN;
            endcase
         end
      end
   end

   assign IRVALID   = (count != '0);
   assign IROUT     = IRVALID ? q_instr[rd_ptr] : '0;
   assign PCOUT     = IRVALID ? q_pc[rd_ptr]    : '0;
   assign HALTED    = (state == S_HALT);
   assign DBG_STATE = state;
   assign DBG_COUNT = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural instruction memory with
// programmable latency, a delivery log and hand-computed expected streams.
module tb_fetch_queue;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic [AW-1:0] RADDR_CPU;
   logic          RREQ;
   logic [DW-1:0] DATA_IN;
   logic          RVALID;
   logic          REDIRECT;
   logic [AW-1:0] REDIRECT_PC;
   logic          STALL;
   logic [DW-1:0] IROUT;
   logic [AW-1:0] PCOUT;
   logic          IRVALID;
   logic          HALTED;
   logic [1:0]    DBG_STATE;
   logic [2:0]    DBG_COUNT;

   always #5 CLK = ~CLK;

   fetch_queue dut (
      .CLK(CLK), .RST(RST), .RADDR_CPU(RADDR_CPU), .RREQ(RREQ),
      .DATA_IN(DATA_IN), .RVALID(RVALID), .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC), .STALL(STALL), .IROUT(IROUT),
      .PCOUT(PCOUT), .IRVALID(IRVALID), .HALTED(HALTED),
      .DBG_STATE(DBG_STATE), .DBG_COUNT(DBG_COUNT)
   );

   logic [DW-1:0] mem [256];
   int            mem_lat;
   int            lat_cnt;
   logic [AW-1:0] pend;
   int            rreq_cnt;
   logic [31:0]   exp_q[$];
   logic [31:0]   got_q[$];
   logic [AW-1:0] raddr_q[$];
   int            total;
   int            bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // One clock: log the pre-edge handshake, then advance the memory model.
   task automatic tick();
      if (IRVALID === 1'b1 && !STALL && !REDIRECT && !RST) got_q.push_back({IROUT, PCOUT});
      @(posedge CLK);
      #1;
      RVALID = 1'b0;
      if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            RVALID  = 1'b1;
            DATA_IN = mem[pend[7:0]];
         end
      end
      if (RREQ === 1'b1) begin
         pend    = RADDR_CPU;
         lat_cnt = mem_lat;
         rreq_cnt++;
         raddr_q.push_back(RADDR_CPU);
      end
   endtask

   task automatic do_reset();
      RST         = 1'b1;
      STALL       = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      RVALID      = 1'b0;
      DATA_IN     = '0;
      lat_cnt     = 0;
      repeat (2) tick();
      RST = 1'b0;
      got_q.delete();
      raddr_q.delete();
      rreq_cnt = 0;
   endtask

   task automatic run_until(input int n, input int budget);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
         else                  check($sformatf("%s_%0d", tag, i), 32'hdead_dead, exp_q[i]);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mem_lat = 1;
      for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);

      // Reset values and straight-line fetch
      do_reset();
      check("rst_raddr",   32'(RADDR_CPU), 32'h0000);
      check("rst_rreq",    32'(RREQ),      0);
      check("rst_irvalid", 32'(IRVALID),   0);
      check("rst_irout",   32'(IROUT),     0);
      check("rst_pcout",   32'(PCOUT),     0);
      check("rst_halted",  32'(HALTED),    0);
      check("rst_count",   32'(DBG_COUNT), 0);
      run_until(3, 60);
      exp_q = '{32'h1000_0000, 32'h1001_0001, 32'h1002_0002};
      check_stream("t1_words");
      check("t1_raddr0", 32'(raddr_q[0]), 32'h0000);
      check("t1_raddr1", 32'(raddr_q[1]), 32'h0001);
      check("t1_raddr2", 32'(raddr_q[2]), 32'h0002);

      // Stall until the queue is full, then drain back-to-back
      do_reset();
      STALL = 1'b1;
      repeat (20) tick();
      check("t2_count", 32'(DBG_COUNT), 4);
      check("t2_rreqs", 32'(rreq_cnt),  4);
      check("t2_rreq",  32'(RREQ),      0);
      check("t2_head",  32'(IROUT),     32'h1000);
      check("t2_pc",    32'(PCOUT),     32'h0000);
      raddr_q.delete();
      STALL = 1'b0;
      repeat (4) tick();
      exp_q = '{32'h1000_0000, 32'h1001_0001, 32'h1002_0002, 32'h1003_0003};
      check_stream("t2_drain");
      run_until(5, 30);
      check("t2_resume_raddr", 32'(raddr_q[0]), 32'h0004);
      check("t2_resume_word",  got_q[4],        32'h1004_0004);

      // Redirect while a slow read is in flight
      do_reset();
      mem_lat = 3;
      tick();
      check("t3_in_wait", 32'(DBG_STATE), 1);
      REDIRECT    = 1'b1;
      REDIRECT_PC = 16'h0040;
      raddr_q.delete();
      tick();
      REDIRECT = 1'b0;
      check("t3_irvalid", 32'(IRVALID),   0);
      check("t3_still_wait", 32'(DBG_STATE), 1);
      run_until(1, 40);
      check("t3_raddr", 32'(raddr_q[0]), 32'h0040);
      check("t3_word",  got_q[0],        32'h1040_0040);

      // HALT opcode stops fetching; redirect restarts it
      do_reset();
      mem_lat = 1;
      mem[3] = 16'hF000;
      repeat (40) tick();
      exp_q = '{32'h1000_0000, 32'h1001_0001, 32'h1002_0002, 32'hF000_0003};
      check_stream("t4_words");
      check("t4_rreqs",  32'(rreq_cnt), 4);
      check("t4_halted", 32'(HALTED),   1);
      rreq_cnt = 0;
      repeat (20) tick();
      check("t4_no_rreq", 32'(rreq_cnt), 0);
      check("t4_drained", 32'(IRVALID),  0);
      REDIRECT    = 1'b1;
      REDIRECT_PC = 16'h0010;
      raddr_q.delete();
      got_q.delete();
      tick();
      REDIRECT = 1'b0;
      check("t4_unhalt", 32'(HALTED), 0);
      run_until(1, 30);
      check("t4_raddr", 32'(raddr_q[0]), 32'h0010);
      check("t4_word",  got_q[0],        32'h1010_0010);
      mem[3] = 16'h1003;

      // Redirect in the same cycle as the response
      do_reset();
      mem_lat = 1;
      tick();
      tick();
      REDIRECT    = 1'b1;
      REDIRECT_PC = 16'h0020;
      raddr_q.delete();
      tick();
      REDIRECT = 1'b0;
      check("t5_irvalid", 32'(IRVALID),   0);
      check("t5_count",   32'(DBG_COUNT), 0);
      check("t5_state",   32'(DBG_STATE), 0);
      run_until(1, 30);
      check("t5_raddr", 32'(raddr_q[0]), 32'h0020);
      check("t5_word",  got_q[0],        32'h1020_0020);

      // Reset during WAIT; the late response lands while in RUN
      do_reset();
      mem_lat = 1;
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      check("t6_irvalid", 32'(IRVALID),   0);
      check("t6_count",   32'(DBG_COUNT), 0);
      check("t6_rreq",    32'(RREQ),      1);
      check("t6_raddr",   32'(RADDR_CPU), 32'h0000);
      tick();
      check("t6_irvalid2", 32'(IRVALID), 0);
      got_q.delete();
      run_until(1, 30);
      check("t6_word", got_q[0], 32'h1000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
